// File: rtl/wheel_brake.sv
// Spinning LED wheel that brakes over a random number of steps with growing intervals.
// Optional `WHEEL_DIR_EN adds dir_i to select decrementing advances.
module wheel_brake #(
    parameter int N_POS     = 8,
    parameter int POS_W     = 3,
    parameter int RAND_W    = 4,
    parameter int MIN_STEPS = 4,
    parameter int DIV_W     = 4,
    parameter int DIV_INC   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_i,
    input  logic              stop_i,
`ifdef WHEEL_DIR_EN
    input  logic              dir_i,
`endif
    input  logic [RAND_W-1:0] rand_i,
    output logic [POS_W-1:0]  pos_o,
    output logic              running_o,
    output logic              done_o
);

    localparam int MAX_DIV = 2**DIV_W - 1;

    typedef enum logic [1:0] {RUN, BRAKE, STOPPED} state_t;

    state_t              state, state_nxt;
    logic [RAND_W:0]     steps, steps_nxt;
    logic [DIV_W-1:0]    div, div_nxt, div_grown;
    logic [DIV_W-1:0]    tcnt, tcnt_nxt;
    logic [DIV_W:0]      div_sum;
    logic [POS_W-1:0]    pos_nxt, pos_adv;
    logic                running_nxt, done_nxt;
    logic                dec, step_due;

`ifdef WHEEL_DIR_EN
    assign dec = dir_i;
`else
    assign dec = 1'b0;
`endif

    always_comb begin
        if (dec)
            pos_adv = (pos_o == '0) ? POS_W'(N_POS - 1) : pos_o - 1'b1;
        else
            pos_adv = (pos_o == POS_W'(N_POS - 1)) ? '0 : pos_o + 1'b1;
    end

    // A tick completes the current brake interval once tcnt+1 reaches div.
    assign step_due  = (({1'b0, tcnt} + 1'b1) == {1'b0, div});
    assign div_sum   = {1'b0, div} + (DIV_W + 1)'(DIV_INC);
    assign div_grown = (div_sum > (DIV_W + 1)'(MAX_DIV)) ? DIV_W'(MAX_DIV) : div_sum[DIV_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RUN;
            pos_o     <= '0;
            running_o <= 1'b1;
            done_o    <= 1'b0;
            steps     <= '0;
            div       <= DIV_W'(1);
            tcnt      <= '0;
        end else begin
            state     <= state_nxt;
            pos_o     <= pos_nxt;
            running_o <= running_nxt;
            done_o    <= done_nxt;
            steps     <= steps_nxt;
            div       <= div_nxt;
            tcnt      <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (stop_i) state_nxt = BRAKE;
            BRAKE: begin
                if (!stop_i)
                    state_nxt = RUN;
                else if (tick_i && step_due && steps == (RAND_W + 1)'(1))
                    state_nxt = STOPPED;
            end
            STOPPED: if (!stop_i) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: every variable gets a hold default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        pos_nxt     = pos_o;
        steps_nxt   = steps;
        div_nxt     = div;
        tcnt_nxt    = tcnt;
        running_nxt = (state_nxt != STOPPED);
        done_nxt    = (state == BRAKE) && (state_nxt == STOPPED);
        case (state)
            RUN: begin
                if (stop_i) begin
                    steps_nxt = {1'b0, rand_i} + (RAND_W + 1)'(MIN_STEPS);
                    div_nxt   = DIV_W'(1);
                    tcnt_nxt  = '0;
                end else if (tick_i) begin
                    pos_nxt = pos_adv;
                end
            end
            BRAKE: begin
                if (!stop_i) begin
                    steps_nxt = '0;
                    div_nxt   = DIV_W'(1);
                    tcnt_nxt  = '0;
                end else if (tick_i) begin
                    if (step_due) begin
                        pos_nxt   = pos_adv;
                        tcnt_nxt  = '0;
                        div_nxt   = div_grown;
                        steps_nxt = steps - 1'b1;
                    end else begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wheel_brake.sv
// Directed bench for wheel_brake: vector table plus brake, wrap and async-reset sequences.
module tb_wheel_brake;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] rnd = '0;
`ifdef WHEEL_DIR_EN
    logic       dir = 1'b0;
`endif
    logic [2:0] pos8, pos6;
    logic       run8, run6, done8, done6;

    always #5 clk = ~clk;

    wheel_brake dut8 (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .stop_i(stop),
`ifdef WHEEL_DIR_EN
        .dir_i(dir),
`endif
        .rand_i(rnd), .pos_o(pos8), .running_o(run8), .done_o(done8)
    );

    wheel_brake #(.N_POS(6), .DIV_W(2)) dut6 (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .stop_i(stop),
`ifdef WHEEL_DIR_EN
        .dir_i(dir),
`endif
        .rand_i(rnd), .pos_o(pos6), .running_o(run6), .done_o(done6)
    );

    typedef struct {
        logic       tick;
        logic       stop;
        logic [3:0] rnd;
        int         pos;
        logic       run;
        logic       done;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after the edge.
    task automatic cyc(input logic t, input logic s, input logic [3:0] r);
        tick = t;
        stop = s;
        rnd  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        tick = 1'b0;
        stop = 1'b0;
        rnd  = '0;
        @(posedge clk);
        #1;
        check("reset_pos", pos8, 0);
        check("reset_run", run8, 1);
        check("reset_done", done8, 0);
        rst = 1'b0;
    endtask

    task automatic add(input logic t, input logic s, input logic [3:0] r,
                       input int p, input logic ru, input logic d);
        vec_t v;
        v.tick = t; v.stop = s; v.rnd = r; v.pos = p; v.run = ru; v.done = d;
        vecs.push_back(v);
    endtask

    initial begin
        int exp_pos;
        int ivl;
        int ticks;
        logic last;

        // Table: idle, ten RUN ticks, brake with abort, brake to rest, release.
        add(0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 10; i++) add(1, 0, 0, i % 8, 1, 0);
        add(1, 1, 0, 2, 1, 0);  // brake entry, coincident tick ignored, S=4
        add(1, 1, 0, 3, 1, 0);  // interval 1
        add(0, 1, 0, 3, 1, 0);
        add(1, 1, 0, 3, 1, 0);
        add(1, 1, 0, 4, 1, 0);  // interval 2 complete
        add(1, 0, 0, 4, 1, 0);  // abort, tick ignored
        add(1, 0, 0, 5, 1, 0);  // RUN advances by one
        add(0, 1, 0, 5, 1, 0);  // re-enter brake, div reloaded to 1
        add(1, 1, 0, 6, 1, 0);
        add(1, 1, 0, 6, 1, 0);
        add(1, 1, 0, 7, 1, 0);
        add(1, 1, 0, 7, 1, 0);
        add(1, 1, 0, 7, 1, 0);
        add(1, 1, 0, 0, 1, 0);
        add(1, 1, 0, 0, 1, 0);
        add(1, 1, 0, 0, 1, 0);
        add(1, 1, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 1);  // fourth step: rest, done pulse
        add(0, 1, 0, 1, 0, 0);
        add(1, 1, 0, 1, 0, 0);  // ticks ignored while stopped
        add(0, 0, 0, 1, 1, 0);  // release
        add(1, 0, 0, 2, 1, 0);

        do_reset();
        foreach (vecs[i]) begin
            cyc(vecs[i].tick, vecs[i].stop, vecs[i].rnd);
            check($sformatf("vec%0d_pos", i), pos8, vecs[i].pos);
            check($sformatf("vec%0d_run", i), run8, vecs[i].run);
            check($sformatf("vec%0d_done", i), done8, vecs[i].done);
        end

        // stop held high out of reset: one RUN cycle, then brake with div=1.
        rst  = 1'b1;
        tick = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 1, 0);
        check("stop_oor_first", pos8, 0);
        cyc(1, 1, 0);
        check("stop_oor_second", pos8, 1);
        check("stop_oor_run", run8, 1);

        // Brake with rand=3 from pos 5: intervals 1..7, 28 ticks, rest at 4.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 0);
        check("t2_start_pos", pos8, 5);
        cyc(0, 1, 3);
        check("t2_entry_pos", pos8, 5);
        exp_pos = 5;
        ticks = 0;
        for (int k = 1; k <= 7; k++) begin
            for (int j = 1; j <= k; j++) begin
                cyc(1, 1, 4'hf);  // rand is only sampled at brake entry
                ticks++;
                if (j == k) exp_pos = (exp_pos + 1) % 8;
                last = (ticks == 28);
                check($sformatf("t2_pos_k%0d_j%0d", k, j), pos8, exp_pos);
                check($sformatf("t2_done_t%0d", ticks), done8, last);
                check($sformatf("t2_run_t%0d", ticks), run8, !last);
            end
        end
        check("t2_final_pos", pos8, 4);
        cyc(0, 1, 3);
        check("t2_done_cleared", done8, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 3);
            check("t2_hold_pos", pos8, 4);
            check("t2_hold_done", done8, 0);
        end
        check("t2_hold_run", run8, 0);

        // Release: running returns next cycle, then three ticks to pos 7.
        cyc(0, 0, 0);
        check("t3_run", run8, 1);
        check("t3_pos", pos8, 4);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        check("t3_final_pos", pos8, 7);

        // Six-position wheel with saturating interval (MAX_DIV=3).
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 0);
            check($sformatf("t5_wrap_%0d", i), pos6, (i + 1) % 6);
        end
        for (int i = 0; i < 4; i++) cyc(1, 0, 0);
        check("t5_start_pos", pos6, 4);
        cyc(0, 1, 2);
        exp_pos = 4;
        ticks = 0;
        for (int k = 1; k <= 6; k++) begin
            ivl = (k < 3) ? k : 3;
            for (int j = 1; j <= ivl; j++) begin
                cyc(1, 1, 2);
                ticks++;
                if (j == ivl) exp_pos = (exp_pos + 1) % 6;
                last = (ticks == 15);
                check($sformatf("t5_pos_t%0d", ticks), pos6, exp_pos);
                check("t5_range", int'(pos6 < 3'd6), 1);
                check($sformatf("t5_done_t%0d", ticks), done6, last);
            end
        end
        check("t5_final_pos", pos6, 4);
        check("t5_final_run", run6, 0);

        // Asynchronous reset between edges during a brake.
        do_reset();
        cyc(0, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        check("t6_pre_pos", pos8, 1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_pos", pos8, 0);
        check("t6_async_run", run8, 1);
        check("t6_async_done", done8, 0);
        @(negedge clk);
        rst = 1'b0;
`ifdef WHEEL_DIR_EN
        dir = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        check("t6_dir_pos", pos8, 5);
        dir = 1'b0;
`else
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        check("t6_fwd_pos", pos8, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
